idct16_odd_serial: RTL

//  Inverse partner of the forward 16-point odd-part shift-add transform in the 32-point DCT path.

---
 rtl/idct_pkg.sv | 39 +++
 rtl/idct_cmul8.sv | 25 ++
 rtl/idct16_odd_serial.sv | 131 +++++++++++++
 3 files changed

// File: rtl/idct_pkg.sv
// Shared definitions for the 16-point odd-part inverse transform: FSM states,
// the eight distinct coefficient magnitudes, and the magnitude-index / sign
// tables that together encode the 8x8 HEVC odd matrix C[k][n].
package idct_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  // Distinct coefficient magnitudes; idct_cmul8 produces x*MAG[i] on output i.
  localparam int MAG [0:7] = '{90, 87, 80, 70, 57, 43, 25, 9};

  // IDX[k][n] selects which magnitude multiplies y_(2k+1) for output o_n.
  localparam logic [2:0] IDX [0:7][0:7] = '{
    '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7},
    '{3'd1, 3'd4, 3'd7, 3'd5, 3'd2, 3'd0, 3'd3, 3'd6},
    '{3'd2, 3'd7, 3'd3, 3'd1, 3'd6, 3'd4, 3'd0, 3'd5},
    '{3'd3, 3'd5, 3'd1, 3'd7, 3'd0, 3'd6, 3'd2, 3'd4},
    '{3'd4, 3'd2, 3'd6, 3'd0, 3'd7, 3'd1, 3'd5, 3'd3},
    '{3'd5, 3'd0, 3'd4, 3'd6, 3'd1, 3'd3, 3'd7, 3'd2},
    '{3'd6, 3'd3, 3'd0, 3'd2, 3'd5, 3'd7, 3'd4, 3'd1},
    '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}
  };

  // NEG[k][n] is 1 where C[k][n] is negative; bit n reads left to right.
  localparam logic [0:7] NEG [0:7] = '{
    8'b0000_0000,
    8'b0001_1111,
    8'b0011_1000,
    8'b0110_0011,
    8'b0110_1100,
    8'b0100_1001,
    8'b0101_0010,
    8'b0101_0101
  };

endpackage

// File: rtl/idct_cmul8.sv
// Multiplier-free constant multiplier bank: x times each of the eight odd
// matrix magnitudes, built from sign-extended shifted copies of x.
module idct_cmul8 #(
  parameter int WIDTH = 16,
  parameter int ACC_W = WIDTH + 10
) (
  input  logic signed [WIDTH-1:0] x,
  output logic signed [ACC_W-1:0] prod [8]
);

  logic signed [ACC_W-1:0] xe;

  // Widen first so every shifted term carries full precision.
  assign xe = {{(ACC_W-WIDTH){x[WIDTH-1]}}, x};

  assign prod[0] = (xe << 6) + (xe << 4) + (xe << 3) + (xe << 1);      // 90
  assign prod[1] = (xe << 6) + (xe << 4) + (xe << 2) + (xe << 1) + xe; // 87
  assign prod[2] = (xe << 6) + (xe << 4);                              // 80
  assign prod[3] = (xe << 6) + (xe << 2) + (xe << 1);                  // 70
  assign prod[4] = (xe << 5) + (xe << 4) + (xe << 3) + xe;             // 57
  assign prod[5] = (xe << 5) + (xe << 3) + (xe << 1) + xe;             // 43
  assign prod[6] = (xe << 4) + (xe << 3) + xe;                         // 25
  assign prod[7] = (xe << 3) + xe;                                     // 9

endmodule

// File: rtl/idct16_odd_serial.sv
// Serial odd-part inverse transform for the 16-point column of the 32-point
// IDCT: one odd coefficient per cycle over 8 cycles feeds 8 accumulators
// that build O[n] = sum_k C[k][n] * y_(2k+1).
module idct16_odd_serial
  import idct_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ACC_W = WIDTH + 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] y1,
  input  logic signed [WIDTH-1:0] y3,
  input  logic signed [WIDTH-1:0] y5,
  input  logic signed [WIDTH-1:0] y7,
  input  logic signed [WIDTH-1:0] y9,
  input  logic signed [WIDTH-1:0] y11,
  input  logic signed [WIDTH-1:0] y13,
  input  logic signed [WIDTH-1:0] y15,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] o0,
  output logic signed [ACC_W-1:0] o1,
  output logic signed [ACC_W-1:0] o2,
  output logic signed [ACC_W-1:0] o3,
  output logic signed [ACC_W-1:0] o4,
  output logic signed [ACC_W-1:0] o5,
  output logic signed [ACC_W-1:0] o6,
  output logic signed [ACC_W-1:0] o7
);

  state_t                  state;
  logic [2:0]              cnt;
  logic signed [WIDTH-1:0] y_reg [8];
  logic signed [WIDTH-1:0] y_sel;
  logic signed [ACC_W-1:0] prod  [8];
  logic signed [ACC_W-1:0] term  [8];
  logic signed [ACC_W-1:0] acc   [8];
  logic                    accept;

  assign accept = (state == IDLE) && in_valid;

  // Capture the block of coefficients when it is accepted.
  // NOTE: the coefficient file has no reset; it is always written before it
  // is read, so a reset here would only add routing to every flop.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      y_reg[0] <= y1;
      y_reg[1] <= y3;
      y_reg[2] <= y5;
      y_reg[3] <= y7;
      y_reg[4] <= y9;
      y_reg[5] <= y11;
      y_reg[6] <= y13;
      y_reg[7] <= y15;
    end
  end

  // Current coefficient, chosen by the step counter.
  always_comb begin
    y_sel = y_reg[cnt];
  end

  idct_cmul8 #(
    .WIDTH(WIDTH),
    .ACC_W(ACC_W)
  ) u_cmul8 (
    .x   (y_sel),
    .prod(prod)
  );

  // Pick each output's magnitude and apply the matrix sign for this row.
  // NOTE: every path assigns term[n], so no latch is inferred.
  always_comb begin
    for (int n = 0; n < 8; n++) begin
      term[n] = NEG[cnt][n] ? -prod[IDX[cnt][n]] : prod[IDX[cnt][n]];
    end
  end

  // Control FSM with registered handshakes and the eight accumulators.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      for (int n = 0; n < 8; n++) acc[n] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state    <= ACCUM;
            cnt      <= '0;
            in_ready <= 1'b0;
            for (int n = 0; n < 8; n++) acc[n] <= '0;
          end
        end
        ACCUM: begin
          for (int n = 0; n < 8; n++) acc[n] <= acc[n] + term[n];
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o0 = acc[0];
  assign o1 = acc[1];
  assign o2 = acc[2];
  assign o3 = acc[3];
  assign o4 = acc[4];
  assign o5 = acc[5];
  assign o6 = acc[6];
  assign o7 = acc[7];

endmodule
